flash_prog_rx: RTL and testbench
================================

Name: flash_prog_rx

Overview:
Upstream stage of the EPCS/ASMI flash programmer. Parses protocol-2 programming packets from the UDP receive byte stream and stages each 256-byte page in an internal page buffer. It commits only complete, valid pages into the programmer Rx FIFO. It also raises the erase request, handles its acknowledge handshake, and latches the total block count consumed by the flash writer.

Parameters:
FIFO_DEPTH, 2048, depth in bytes of the downstream Rx FIFO (fifo_wrused range)
PAGE_BYTES, 256, bytes per program page; fixed value, not user-tunable
ERASE_TIMEOUT, 25000000, clock cycles to hold erase without erase_ACK before giving up

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
rx_valid  in  1  byte strobe for rx_data
rx_sop  in  1  qualifies first byte of packet (with rx_valid)
rx_eop  in  1  qualifies last byte of packet (with rx_valid)
rx_data  in  8  packet byte
fifo_wrused  in  11  current Rx FIFO fill level
fifo_wrreq  out  1  FIFO write strobe
fifo_data  out  8  FIFO write data
erase  out  1  erase request, level
erase_ACK  in  1  erase request seen by flash writer
num_blocks  out  14  total pages of image, from last accepted program packet
pkt_drop  out  1  one-cycle pulse per dropped packet
seq_err  out  1  one-cycle pulse on sequence mismatch (macro only; else tied 0)

Behaviour:
- Packet format: bytes 0-3 sequence number (big-endian); byte 4 command (0x01 program, 0x02 erase, other values are ignored); program packets add bytes 5-8 block count (big-endian, low 14 bits used) followed by 256 data bytes. Program packet length is exactly 265 bytes.
- Reset values: fifo_wrreq=0, fifo_data=0, erase=0, num_blocks=0, pkt_drop=0, seq_err=0, state=IDLE, expected seq=0.
- States:
  - IDLE: wait for rx_valid&rx_sop -> HDR; byte index=0.
  - HDR: collect bytes 0-4. Byte 4 = 0x01 -> BLK. Byte 4 = 0x02 -> wait for eop, then ERASE. Any other command -> DISCARD.
  - BLK: collect bytes 5-8 into a holding register (num_blocks not yet updated) -> DATA.
  - DATA: write bytes 9..264 to page buffer address 0..255.
    - rx_eop on byte 264 -> CHECK.
    - eop earlier -> drop (pkt_drop), IDLE.
    - 256 bytes received without eop -> DISCARD, which then drops.
  - CHECK (1 cycle): accept if fifo_wrused <= FIFO_DEPTH-PAGE_BYTES (i.e. <=1792), else drop. On accept, num_blocks <= holding[13:0] and go to DRAIN.
  - DRAIN: 256 consecutive cycles with fifo_wrreq=1, fifo_data=buffer[0..255] in order, then IDLE. The buffer is read synchronously; the first fifo_wrreq occurs 2 cycles after the CHECK cycle.
  - DISCARD: ignore bytes until rx_eop, then IDLE.
  - ERASE: erase=1 and counter cleared. Exit to IDLE with erase=0 on the cycle after erase_ACK=1, or when the counter reaches ERASE_TIMEOUT (pkt_drop pulses on timeout).
- Incoming bytes while in DRAIN or ERASE: the packet is discarded, pkt_drop pulses once at its eop, and the block stays in its current state.
- rx_sop in the middle of a packet in any parse state: abandon the current packet (pkt_drop), restart HDR with this byte as byte 0.
- Sequence number, byte counter and timeout counter are unsigned; seq wraps 0xFFFFFFFF->0.
- Reset in the middle of DRAIN stops writes on the next cycle; a partial page already in the FIFO is not retracted.

Optional Feature:
SEQ_CHECK_EN: when defined, each accepted packet's sequence number must equal expected seq. A mismatch pulses seq_err and pkt_drop, the packet is discarded, and expected seq resyncs to received+1. Expected seq increments on every accepted packet, and an erase packet resets it so the next packet must be 1. When undefined, sequence bytes are parsed but ignored and seq_err is constant 0.

Test Plan:
- Erase packet seq=0, cmd=0x02; erase_ACK asserted 10 cycles later -> erase high exactly 11 cycles then 0; no FIFO writes.
- Program packet, blocks=0x00000C00, data 0x00..0xFF, fifo_wrused=0 -> num_blocks=0xC00; 256 fifo_wrreq cycles with data 0x00..0xFF in order.
- Same packet with fifo_wrused=1793 -> pkt_drop pulse, zero FIFO writes, num_blocks unchanged.
- Program packet truncated to 200 bytes (eop on byte 199) -> pkt_drop, no FIFO writes; next valid packet accepted normally.
- SEQ_CHECK_EN: packets seq 1,2,4 after erase -> third gives seq_err and pkt_drop; a following seq 5 is accepted.
- Erase with erase_ACK never asserted, ERASE_TIMEOUT=100 -> erase low after 100 cycles, pkt_drop pulse, back to IDLE.

Source files
------------

// File: rtl/flash_prog_rx.sv
// Protocol-2 packet parser for the EPCS/ASMI programmer: stages one page, commits it to the Rx FIFO, drives erase.
// Optional sequence-number enforcement is compiled in with `define SEQ_CHECK_EN.
module flash_prog_rx #(
    parameter int FIFO_DEPTH    = 2048,
    parameter int PAGE_BYTES    = 256,
    parameter int ERASE_TIMEOUT = 25000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic        rx_sop,
    input  logic        rx_eop,
    input  logic [7:0]  rx_data,
    input  logic [10:0] fifo_wrused,
    output logic        fifo_wrreq,
    output logic [7:0]  fifo_data,
    output logic        erase,
    input  logic        erase_ACK,
    output logic [13:0] num_blocks,
    output logic        pkt_drop,
    output logic        seq_err
);

    localparam int AW = $clog2(PAGE_BYTES);
    localparam int TW = $clog2(ERASE_TIMEOUT + 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(PAGE_BYTES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(ERASE_TIMEOUT - 1);
    localparam logic [10:0]   WR_LIMIT  = 11'(FIFO_DEPTH - PAGE_BYTES);
    localparam logic [7:0]    CMD_PROG  = 8'h01;
    localparam logic [7:0]    CMD_ERASE = 8'h02;

    typedef enum logic [3:0] {
        IDLE, HDR, BLK, DATA, CHECK, DRAIN, DISCARD, ERASE_WAIT, ERASE
    } state_t;

    state_t          state, state_nxt;
    logic [3:0]      idx;
    logic [13:0]     blk_hold;
    logic [AW-1:0]   wr_addr;
    logic [AW-1:0]   rd_cnt;
    logic [TW-1:0]   tmo_cnt;
    logic            drop_pend, pend_nxt;
    logic            bsy_pkt, bsy_nxt;
    logic            drop_nxt, restart, accept, erase_go, mem_we;
    logic            sop_in, eop_in, last_data;
    logic [7:0]      page_mem [PAGE_BYTES];
`ifdef SEQ_CHECK_EN
    logic [31:0]     seq_rx;
    logic [31:0]     exp_seq;
    logic            serr_nxt;
`endif

    assign sop_in    = rx_valid & rx_sop;
    assign eop_in    = rx_valid & rx_eop;
    assign last_data = (wr_addr == LAST_ADDR);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        drop_nxt  = 1'b0;
        restart   = 1'b0;
        accept    = 1'b0;
        erase_go  = 1'b0;
        mem_we    = 1'b0;
        pend_nxt  = drop_pend;
        bsy_nxt   = bsy_pkt;
`ifdef SEQ_CHECK_EN
        serr_nxt  = 1'b0;
`endif
        // A new sop inside any parse state abandons the current packet and restarts on this byte.
        if ((state inside {HDR, BLK, DATA, DISCARD, ERASE_WAIT}) && sop_in) begin
            restart   = 1'b1;
            pend_nxt  = 1'b0;
            drop_nxt  = (state == DISCARD) ? (drop_pend | eop_in) : 1'b1;
            state_nxt = eop_in ? IDLE : HDR;
        end else begin
            unique case (state)
                IDLE: begin
                    if (sop_in) begin
                        restart   = 1'b1;
                        pend_nxt  = 1'b0;
                        bsy_nxt   = 1'b0;
                        drop_nxt  = bsy_pkt | eop_in;
                        state_nxt = eop_in ? IDLE : HDR;
                    end else if (eop_in && bsy_pkt) begin
                        drop_nxt = 1'b1;
                        bsy_nxt  = 1'b0;
                    end
                end
                HDR: begin
                    if (rx_valid) begin
                        if (idx != 4'd4) begin
                            if (eop_in) begin
                                drop_nxt  = 1'b1;
                                state_nxt = IDLE;
                            end
                        end else if (rx_data == CMD_PROG) begin
`ifdef SEQ_CHECK_EN
                            if (seq_rx != exp_seq) begin
                                serr_nxt  = 1'b1;
                                drop_nxt  = 1'b1;
                                pend_nxt  = 1'b0;
                                state_nxt = eop_in ? IDLE : DISCARD;
                            end else
`endif
                            if (eop_in) begin
                                drop_nxt  = 1'b1;
                                state_nxt = IDLE;
                            end else begin
                                state_nxt = BLK;
                            end
                        end else if (rx_data == CMD_ERASE) begin
                            erase_go  = eop_in;
                            state_nxt = eop_in ? ERASE : ERASE_WAIT;
                        end else begin
                            pend_nxt  = 1'b0;
                            state_nxt = eop_in ? IDLE : DISCARD;
                        end
                    end
                end
                BLK: begin
                    if (eop_in) begin
                        drop_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else if (rx_valid && idx == 4'd8) begin
                        state_nxt = DATA;
                    end
                end
                DATA: begin
                    if (rx_valid) begin
                        mem_we = 1'b1;
                        if (eop_in) begin
                            drop_nxt  = ~last_data;
                            state_nxt = last_data ? CHECK : IDLE;
                        end else if (last_data) begin
                            pend_nxt  = 1'b1;
                            state_nxt = DISCARD;
                        end
                    end
                end
                DISCARD: begin
                    if (eop_in) begin
                        drop_nxt  = drop_pend;
                        state_nxt = IDLE;
                    end
                end
                ERASE_WAIT: begin
                    if (eop_in) begin
                        erase_go  = 1'b1;
                        state_nxt = ERASE;
                    end
                end
                CHECK: begin
                    if (fifo_wrused <= WR_LIMIT) begin
                        accept    = 1'b1;
                        state_nxt = DRAIN;
                    end else begin
                        drop_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                DRAIN: begin
                    if (rd_cnt == LAST_ADDR) state_nxt = IDLE;
                end
                ERASE: begin
                    if (erase_ACK) begin
                        state_nxt = IDLE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        drop_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        // Packets arriving while busy are swallowed; the drop is reported at their eop, even after returning to IDLE.
        if (state inside {CHECK, DRAIN, ERASE}) begin
            if (sop_in) begin
                bsy_nxt = 1'b1;
                if (bsy_pkt) drop_nxt = 1'b1;
            end
            if (eop_in && (bsy_pkt || sop_in)) begin
                drop_nxt = 1'b1;
                bsy_nxt  = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) page_mem[wr_addr] <= rx_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fifo_wrreq <= 1'b0;
            fifo_data  <= 8'd0;
            erase      <= 1'b0;
            num_blocks <= 14'd0;
            pkt_drop   <= 1'b0;
            idx        <= 4'd0;
            blk_hold   <= 14'd0;
            wr_addr    <= '0;
            rd_cnt     <= '0;
            tmo_cnt    <= '0;
            drop_pend  <= 1'b0;
            bsy_pkt    <= 1'b0;
        end else begin
            fifo_wrreq <= (state == DRAIN);
            erase      <= (state_nxt == ERASE);
            pkt_drop   <= drop_nxt;
            drop_pend  <= pend_nxt;
            bsy_pkt    <= bsy_nxt;
            rd_cnt     <= (state == DRAIN) ? rd_cnt + 1'b1 : '0;
            tmo_cnt    <= (state == ERASE) ? tmo_cnt + 1'b1 : '0;
            if (state == DRAIN) fifo_data <= page_mem[rd_cnt];
            if (restart) begin
                idx     <= 4'd1;
                wr_addr <= '0;
            end else begin
                if (rx_valid && (state == HDR || state == BLK)) idx <= idx + 4'd1;
                if (mem_we) wr_addr <= wr_addr + 1'b1;
            end
            if (rx_valid && state == BLK) blk_hold <= {blk_hold[5:0], rx_data};
            if (accept) num_blocks <= blk_hold;
        end
    end

`ifdef SEQ_CHECK_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            seq_rx  <= 32'd0;
            exp_seq <= 32'd0;
            seq_err <= 1'b0;
        end else begin
            seq_err <= serr_nxt;
            if (restart)
                seq_rx <= {24'd0, rx_data};
            else if (rx_valid && state == HDR && idx < 4'd4)
                seq_rx <= {seq_rx[23:0], rx_data};
            // Erase opens a new session: the next program packet must carry seq 1.
            if (erase_go)
                exp_seq <= 32'd1;
            else if (accept || serr_nxt)
                exp_seq <= seq_rx + 32'd1;
        end
    end
`else
    assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_flash_prog_rx.sv
// Directed bench for flash_prog_rx: erase handshake/timeout, page commit, FIFO-full, truncation, busy and reset cases.
module tb_flash_prog_rx;
    localparam int TMO = 100;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rx_valid = 1'b0, rx_sop = 1'b0, rx_eop = 1'b0, erase_ACK = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic [10:0] fifo_wrused = 11'd0;
    logic        fifo_wrreq, erase, pkt_drop, seq_err;
    logic [7:0]  fifo_data;
    logic [13:0] num_blocks;

    int n_chk = 0, n_fail = 0;
    int wr_cnt = 0, drop_cnt = 0, serr_cnt = 0, cyc = 0, first_wr = 0;
    logic prev_wr = 1'b0;
    logic [7:0] cap [0:4095];
    logic [7:0] pkt [0:299];

    always #5 clock = ~clock;

    flash_prog_rx #(.FIFO_DEPTH(2048), .PAGE_BYTES(256), .ERASE_TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_sop(rx_sop), .rx_eop(rx_eop),
        .rx_data(rx_data), .fifo_wrused(fifo_wrused), .fifo_wrreq(fifo_wrreq), .fifo_data(fifo_data),
        .erase(erase), .erase_ACK(erase_ACK), .num_blocks(num_blocks), .pkt_drop(pkt_drop),
        .seq_err(seq_err)
    );

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (fifo_wrreq) begin
            cap[wr_cnt % 4096] = fifo_data;
            if (!prev_wr) first_wr = cyc;
            wr_cnt++;
        end
        prev_wr = fifo_wrreq;
        if (pkt_drop) drop_cnt++;
        if (seq_err) serr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic build(input logic [31:0] seq, input logic [7:0] cmd, input logic [31:0] blk,
                         input logic [7:0] xr);
        for (int i = 0; i < 300; i++) pkt[i] = 8'd0;
        for (int i = 0; i < 4; i++) begin
            pkt[i]     = seq[31-8*i -: 8];
            pkt[5 + i] = blk[31-8*i -: 8];
        end
        pkt[4] = cmd;
        for (int i = 0; i < 256; i++) pkt[9 + i] = 8'(i) ^ xr;
    endtask

    task automatic send(input int len);
        for (int i = 0; i < len; i++) begin
            rx_valid = 1'b1;
            rx_sop   = (i == 0);
            rx_eop   = (i == len - 1);
            rx_data  = pkt[i];
            @(negedge clock);
        end
        rx_valid = 1'b0;
        rx_sop   = 1'b0;
        rx_eop   = 1'b0;
    endtask

    // Counts negedge samples with erase high; ack_at < 0 never acknowledges.
    task automatic erase_hold(input int ack_at, output int hi);
        int n;
        n  = 0;
        hi = 0;
        while (!erase && n < 20) begin
            @(negedge clock);
            n++;
        end
        while (erase && hi < 1000) begin
            if (hi == ack_at) erase_ACK = 1'b1;
            @(negedge clock);
            hi++;
        end
        erase_ACK = 1'b0;
    endtask

    task automatic page_errs(input int base, input logic [7:0] xr, output int e);
        e = 0;
        for (int i = 0; i < 256; i++)
            if (cap[(base + i) % 4096] !== (8'(i) ^ xr)) e++;
    endtask

    initial begin
        int b_wr, b_drop, b_serr, hi, e, eop_cyc, n;

        idle(3);
        reset = 1'b0;
        idle(1);
        check("rst_wrreq", fifo_wrreq, 0);
        check("rst_data", fifo_data, 0);
        check("rst_erase", erase, 0);
        check("rst_blocks", num_blocks, 0);
        check("rst_drop", pkt_drop, 0);
        check("rst_seqerr", seq_err, 0);

        // erase acknowledged 10 cycles after it rises
        b_wr = wr_cnt; b_drop = drop_cnt;
        build(0, 8'h02, 0, 0);
        send(5);
        erase_hold(10, hi);
        check("erase_ack_hold", hi, 11);
        idle(5);
        check("erase_no_wr", wr_cnt - b_wr, 0);
        check("erase_no_drop", drop_cnt - b_drop, 0);

        // full page accepted
        b_wr = wr_cnt; b_drop = drop_cnt;
        build(1, 8'h01, 32'h0000_0C00, 8'h00);
        send(265);
        eop_cyc = cyc;
        idle(280);
        check("prog_blocks", num_blocks, 14'h0C00);
        check("prog_wr", wr_cnt - b_wr, 256);
        check("prog_latency", first_wr - eop_cyc, 2);
        page_errs(b_wr, 8'h00, e);
        check("prog_data", e, 0);
        check("prog_drop", drop_cnt - b_drop, 0);

        // FIFO one byte too full
        b_wr = wr_cnt; b_drop = drop_cnt;
        fifo_wrused = 11'd1793;
        build(2, 8'h01, 32'h0000_0123, 8'h00);
        send(265);
        idle(20);
        check("full_drop", drop_cnt - b_drop, 1);
        check("full_wr", wr_cnt - b_wr, 0);
        check("full_blocks", num_blocks, 14'h0C00);

        // exactly at the limit; upper block-count bits discarded
        b_wr = wr_cnt; b_drop = drop_cnt;
        fifo_wrused = 11'd1792;
        build(2, 8'h01, 32'hFFFF_FFFF, 8'h3C);
        send(265);
        idle(280);
        check("edge_blocks", num_blocks, 14'h3FFF);
        check("edge_wr", wr_cnt - b_wr, 256);
        page_errs(b_wr, 8'h3C, e);
        check("edge_data", e, 0);
        check("edge_drop", drop_cnt - b_drop, 0);
        fifo_wrused = 11'd0;

        // truncated then good packet
        b_wr = wr_cnt; b_drop = drop_cnt;
        build(3, 8'h01, 32'h0000_0005, 8'h00);
        send(200);
        idle(20);
        check("trunc_drop", drop_cnt - b_drop, 1);
        check("trunc_wr", wr_cnt - b_wr, 0);
        b_wr = wr_cnt;
        build(3, 8'h01, 32'h0000_0055, 8'hA5);
        send(265);
        idle(280);
        check("after_trunc_blocks", num_blocks, 14'h0055);
        check("after_trunc_wr", wr_cnt - b_wr, 256);
        page_errs(b_wr, 8'hA5, e);
        check("after_trunc_data", e, 0);

        // erase never acknowledged
        b_drop = drop_cnt;
        build(7, 8'h02, 0, 0);
        send(5);
        erase_hold(-1, hi);
        idle(3);
        check("tmo_hold", hi, TMO);
        check("tmo_drop", drop_cnt - b_drop, 1);
        check("tmo_erase_low", erase, 0);

        // unknown command silently ignored
        b_wr = wr_cnt; b_drop = drop_cnt;
        build(1, 8'h07, 32'h0000_0001, 8'h00);
        send(265);
        idle(20);
        check("unk_drop", drop_cnt - b_drop, 0);
        check("unk_wr", wr_cnt - b_wr, 0);

        // overlong program packet
        b_wr = wr_cnt; b_drop = drop_cnt;
        build(1, 8'h01, 32'h0000_0009, 8'h00);
        send(270);
        idle(20);
        check("ovf_drop", drop_cnt - b_drop, 1);
        check("ovf_wr", wr_cnt - b_wr, 0);
        check("ovf_blocks", num_blocks, 14'h0055);

        // second packet lands while draining
        b_wr = wr_cnt; b_drop = drop_cnt;
        build(1, 8'h01, 32'h0000_0077, 8'h11);
        send(265);
        build(2, 8'h01, 32'h0000_0099, 8'h22);
        send(265);
        idle(300);
        check("busy_wr", wr_cnt - b_wr, 256);
        check("busy_drop", drop_cnt - b_drop, 1);
        check("busy_blocks", num_blocks, 14'h0077);
        page_errs(b_wr, 8'h11, e);
        check("busy_data", e, 0);

`ifdef SEQ_CHECK_EN
        build(0, 8'h02, 0, 0);
        send(5);
        erase_hold(3, hi);
        idle(3);
        b_wr = wr_cnt; b_drop = drop_cnt; b_serr = serr_cnt;
        for (int k = 0; k < 4; k++) begin
            n = (k == 3) ? 5 : ((k == 2) ? 4 : k + 1);
            build(32'(n), 8'h01, 32'(n), 8'h00);
            send(265);
            idle(280);
        end
        check("seq_err_cnt", serr_cnt - b_serr, 1);
        check("seq_drop", drop_cnt - b_drop, 1);
        check("seq_wr", wr_cnt - b_wr, 768);
        check("seq_blocks", num_blocks, 14'd5);
        n = 6;
`else
        check("seq_err_quiet", serr_cnt, 0);
        n = 9;
`endif

        // reset in the middle of a drain
        b_wr = wr_cnt;
        build(32'(n), 8'h01, 32'h0000_0011, 8'h00);
        send(265);
        e = 0;
        while (!fifo_wrreq && e < 20) begin
            @(negedge clock);
            e++;
        end
        check("drain_start", fifo_wrreq, 1);
        idle(9);
        reset = 1'b1;
        idle(1);
        check("rst_mid_wrreq", fifo_wrreq, 0);
        check("rst_mid_blocks", num_blocks, 0);
        reset = 1'b0;
        idle(5);
        check("rst_mid_wr", wr_cnt - b_wr, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
